// File: rtl/fix_signdiv.sv
// Sequential signed fixed-point divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Define FIX_SIGNDIV_SAT_EN to saturate the quotient on error; otherwise an errored quotient reads 0.
module fix_signdiv #(
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 2*INPUT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [OUTPUT_WIDTH-1:0] dividend,
   input  logic [INPUT_WIDTH-1:0]  divisor,
   output logic                    busy,
   output logic                    done,
   output logic [INPUT_WIDTH-1:0]  quotient,
   output logic [INPUT_WIDTH-1:0]  remainder,
   output logic                    div_by_zero,
   output logic                    overflow
);

   localparam int W  = INPUT_WIDTH;
   localparam int CW = $clog2(INPUT_WIDTH);
   localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINNEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PREP, DIV, FIX} state_t;

   state_t state, state_nxt;

   logic [OUTPUT_WIDTH-1:0] dvd_q;
   logic [W-1:0]            dvs_q;
   logic [W-1:0]            rem;
   logic [W-1:0]            low;
   logic [W-1:0]            dvs_abs_q;
   logic [W-1:0]            qm;
   logic [CW-1:0]           cnt;
   logic                    neg_q;
   logic                    dvd_neg_q;
   logic                    dbz_q;
   logic                    ovf_q;

   logic [OUTPUT_WIDTH-1:0] dvd_abs;
   logic [W-1:0]            dvd_hi;
   logic [W-1:0]            dvd_lo;
   logic [W-1:0]            dvs_abs;
   logic                    prep_dbz;
   logic                    prep_ovf;
   logic [W:0]              rem_sh;
   logic [W-1:0]            rem_sub;
   logic                    fits;

   logic                    late_ovf;
   logic                    ovf_res;
   logic [W-1:0]            q_res;
   logic [W-1:0]            r_res;

   // Magnitudes are unsigned so the most negative operands need no special case.
   assign dvd_abs  = dvd_q[OUTPUT_WIDTH-1] ? -dvd_q : dvd_q;
   assign dvd_hi   = dvd_abs[OUTPUT_WIDTH-1:W];
   assign dvd_lo   = dvd_abs[W-1:0];
   assign dvs_abs  = dvs_q[W-1] ? -dvs_q : dvs_q;
   assign prep_dbz = (dvs_q == '0);
   assign prep_ovf = !prep_dbz && (dvd_hi >= dvs_abs);

   // One restoring step; the difference fits in W bits whenever the trial subtraction succeeds.
   assign rem_sh  = {rem, low[W-1]};
   assign fits    = (rem_sh >= {1'b0, dvs_abs_q});
   assign rem_sub = rem_sh[W-1:0] - dvs_abs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PREP;
         PREP:    state_nxt = (prep_dbz || prep_ovf) ? FIX : DIV;
         DIV:     if (cnt == CW'(W-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sign fix-up and error selection, consumed only in the FIX cycle.
   always_comb begin
      late_ovf = neg_q ? (qm > MINNEG) : (qm > MAXPOS);
      ovf_res  = !dbz_q && (ovf_q || late_ovf);
      q_res    = neg_q ? -qm : qm;
      r_res    = dvd_neg_q ? -rem : rem;
      if (dbz_q || ovf_res) begin
         r_res = '0;
`ifdef FIX_SIGNDIV_SAT_EN
         q_res = (dbz_q ? dvd_neg_q : neg_q) ? MINNEG : MAXPOS;
`else
         q_res = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem         <= '0;
         low         <= '0;
         dvs_abs_q   <= '0;
         qm          <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         dvd_neg_q   <= 1'b0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_q <= dividend;
                  dvs_q <= divisor;
               end
            end
            PREP: begin
               neg_q     <= dvd_q[OUTPUT_WIDTH-1] ^ dvs_q[W-1];
               dvd_neg_q <= dvd_q[OUTPUT_WIDTH-1];
               dbz_q     <= prep_dbz;
               ovf_q     <= prep_ovf;
               rem       <= dvd_hi;
               low       <= dvd_lo;
               dvs_abs_q <= dvs_abs;
               qm        <= '0;
               cnt       <= '0;
            end
            DIV: begin
               rem <= fits ? rem_sub : rem_sh[W-1:0];
               low <= {low[W-2:0], 1'b0};
               qm  <= {qm[W-2:0], fits};
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               quotient    <= q_res;
               remainder   <= r_res;
               div_by_zero <= dbz_q;
               overflow    <= ovf_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fix_signdiv.sv
// Self-checking bench for fix_signdiv: directed cases plus randomized operands against an arithmetic model.
module tb_fix_signdiv;

   localparam int W = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   fix_signdiv #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference: plain signed division on 64-bit integers, then the error rules.
   function automatic void model(input logic signed [31:0] dvd, input logic signed [15:0] dvs,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic dbz, output logic ovf, output int lat);
      longint a, b, qt, rt, aa, bb;
      a = dvd;
      b = dvs;
      dbz = 1'b0;
      ovf = 1'b0;
      if (b == 0) begin
         dbz = 1'b1;
         r = '0;
`ifdef FIX_SIGNDIV_SAT_EN
         q = (a >= 0) ? 16'h7fff : 16'h8000;
`else
         q = '0;
`endif
         lat = 2;
      end else begin
         qt = a / b;
         rt = a % b;
         aa = (a < 0) ? -a : a;
         bb = (b < 0) ? -b : b;
         lat = (aa >= bb * 65536) ? 2 : W + 2;
         if (qt > 32767 || qt < -32768) begin
            ovf = 1'b1;
            r = '0;
`ifdef FIX_SIGNDIV_SAT_EN
            q = (qt > 0) ? 16'h7fff : 16'h8000;
`else
            q = '0;
`endif
         end else begin
            q = 16'(qt);
            r = 16'(rt);
         end
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one request and waits (bounded) for done; optionally pulses a second start mid-flight.
   task automatic applyStimulus(input logic signed [31:0] dvd, input logic signed [15:0] dvs,
                                input int inject_at, output int lat, output bit busy_ok);
      @(negedge clk);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (!done && lat < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (lat == inject_at) begin
            dividend = 32'd99999;
            divisor  = 16'd3;
            start    = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
      end
   endtask

   task automatic runOp(input string tag, input logic signed [31:0] dvd, input logic signed [15:0] dvs,
                        input int inject_at);
      logic [15:0] eq, er;
      logic        edbz, eovf;
      int          elat, lat;
      bit          busy_ok;
      model(dvd, dvs, eq, er, edbz, eovf, elat);
      applyStimulus(dvd, dvs, inject_at, lat, busy_ok);
      checkOutput({tag, " latency"}, 32'(lat), 32'(elat));
      checkOutput({tag, " quotient"}, {16'h0, quotient}, {16'h0, eq});
      checkOutput({tag, " remainder"}, {16'h0, remainder}, {16'h0, er});
      checkOutput({tag, " div_by_zero"}, {31'h0, div_by_zero}, {31'h0, edbz});
      checkOutput({tag, " overflow"}, {31'h0, overflow}, {31'h0, eovf});
      checkOutput({tag, " busy before done"}, {31'h0, busy_ok}, 32'h1);
      checkOutput({tag, " busy with done"}, {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput({tag, " done pulse"}, {31'h0, done}, 32'h0);
      checkOutput({tag, " quotient hold"}, {16'h0, quotient}, {16'h0, eq});
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " busy"}, {31'h0, busy}, 32'h0);
      checkOutput({tag, " done"}, {31'h0, done}, 32'h0);
      checkOutput({tag, " quotient"}, {16'h0, quotient}, 32'h0);
      checkOutput({tag, " remainder"}, {16'h0, remainder}, 32'h0);
      checkOutput({tag, " div_by_zero"}, {31'h0, div_by_zero}, 32'h0);
      checkOutput({tag, " overflow"}, {31'h0, overflow}, 32'h0);
   endtask

   initial begin
      bit          seen_done;
      logic [31:0] rdvd;
      logic [15:0] rdvs;
      longint      qs, ds, rr, mag;
      int          kind;

      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      runOp("500/5", 32'sd500, 16'sd5, -1);
      runOp("product round trip", -32'sd1218000, 16'sd75, -1);
      runOp("product plus remainder", -32'sd1218007, 16'sd75, -1);
      runOp("divide by zero", 32'sd1234, 16'sd0, -1);
      runOp("negative divide by zero", -32'sd9, 16'sd0, -1);
      runOp("early overflow", 32'sd65536, 16'sd1, -1);
      runOp("late overflow", 32'sd32768, 16'sd1, -1);
      runOp("min quotient neg divisor", 32'sd32768, -16'sd1, -1);
      runOp("min quotient neg dividend", -32'sd32768, 16'sd1, -1);
      runOp("most negative over -1", 32'h8000_0000, -16'sd1, -1);
      runOp("most negative over min", 32'h8000_0000, 16'h8000, -1);
      runOp("zero dividend", 32'sd0, -16'sd7, -1);
      runOp("start while busy", 32'sd100, 16'sd7, 5);

      // Abandon an operation mid-division; outputs must clear at once and no done may follow.
      @(negedge clk);
      dividend = 32'sd1000;
      divisor  = 16'sd3;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkAllZero("mid-div reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      checkOutput("no done after reset", {31'h0, seen_done}, 32'h0);

      runOp("after reset -20/3", -32'sd20, 16'sd3, -1);

      for (int i = 0; i < 40; i++) begin
         kind = int'($urandom_range(0, 3));
         rdvs = 16'($urandom);
         rdvd = $urandom;
         if (kind == 1) begin
            ds  = longint'($signed(rdvs));
            qs  = longint'($signed(16'($urandom)));
            mag = (ds < 0) ? -ds : ds;
            rr  = (mag > 1) ? longint'($urandom_range(0, 32'(mag - 1))) : 0;
            if (qs < 0) rr = -rr;
            rdvd = 32'(qs * ds + rr);
         end else if (kind == 2) begin
            rdvs = '0;
         end else if (kind == 3) begin
            rdvs = 16'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) rdvs = -rdvs;
            rdvd = 32'($signed(21'($urandom)));
         end
         runOp($sformatf("random %0d", i), rdvd, rdvs, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
